// File: rtl/kmeans_pkg.sv
// Shared k-means constants and the centroid-update FSM state type.
// Pure declarations; no logic, latency or flow control.
package kmeans_pkg;
    localparam int KMEANS_K = 2;
    localparam int KMEANS_N = 2;
    localparam int unsigned KMEANS_CONV_TOL = 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DIV,
        WRITE,
        DONE
    } kmeans_state_t;
endpackage

// File: rtl/kmeans_seq_div.sv
// Restoring unsigned divider: one quotient bit per cycle, acc_width cycles after load.
// No backpressure: load restarts the operation; valid rises after the last step.
module kmeans_seq_div #(
    parameter int acc_width                = 16,
    parameter int input_data_qty_bit_width = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                load,
    input  logic [acc_width-1:0]                dividend,
    input  logic [input_data_qty_bit_width-1:0] divisor,
    output logic [acc_width-1:0]                quotient,
    output logic                                valid
);
    localparam int QW = input_data_qty_bit_width;
    localparam int CW = $clog2(acc_width + 1);

    logic [QW-1:0] rem_q;
    logic [QW-1:0] dsr_q;
    logic [CW-1:0] cnt_q;
    logic [QW:0]   rem_sh;

    // Quotient register doubles as the dividend shift register.
    assign rem_sh = {rem_q, quotient[acc_width-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            quotient <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            rem_q    <= '0;
            dsr_q    <= divisor;
            cnt_q    <= CW'(acc_width);
            quotient <= dividend;
            valid    <= 1'b0;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            valid <= (cnt_q == CW'(1));
            if (rem_sh >= {1'b0, dsr_q}) begin
                rem_q    <= QW'(rem_sh - {1'b0, dsr_q});
                quotient <= {quotient[acc_width-2:0], 1'b1};
            end else begin
                rem_q    <= rem_sh[QW-1:0];
                quotient <= {quotient[acc_width-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/kmeans_centroid_update_k2n2.sv
// Centroid update: reads sums/counts per centroid, divides, saturates, reports convergence; done 37 cycles after start.
// No backpressure: start ignored while busy; KMEANS_UPDATE_TOL_EN selects tolerance-based matching.
module kmeans_centroid_update_k2n2
    import kmeans_pkg::*;
#(
    parameter int input_data_width         = 8,
    parameter int input_data_qty_bit_width = 8,
    parameter int acc_width                = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [input_data_width-1:0]         k0d0,
    input  logic [input_data_width-1:0]         k0d1,
    input  logic [input_data_width-1:0]         k1d0,
    input  logic [input_data_width-1:0]         k1d1,
    output logic                                rd_acc_en,
    output logic                                rd_acc_centroid,
    input  logic [acc_width-1:0]                acc0_in,
    input  logic [acc_width-1:0]                acc1_in,
    input  logic [input_data_qty_bit_width-1:0] acc_counter_in,
    output logic [input_data_width-1:0]         new_k0d0,
    output logic [input_data_width-1:0]         new_k0d1,
    output logic [input_data_width-1:0]         new_k1d0,
    output logic [input_data_width-1:0]         new_k1d1,
    output logic                                busy,
    output logic                                done,
    output logic                                converged
);
    localparam int DW = input_data_width;
    localparam int CW = $clog2(acc_width + 1);

    kmeans_state_t state_q, state_d;
    logic          c_q;
    logic [CW-1:0] div_cnt_q;
    logic [input_data_qty_bit_width-1:0] cnt_q;
    logic [DW-1:0] old_k0d0, old_k0d1, old_k1d0, old_k1d1;
    logic [1:0]    match_q;
    logic [acc_width-1:0] quo0, quo1;
    logic          vld0, vld1;
    logic [DW-1:0] old_d0, old_d1, upd_d0, upd_d1;
    logic          upd_match;
    logic          start_acc;

    function automatic logic [DW-1:0] sat(input logic [acc_width-1:0] q);
        return (q > acc_width'((1 << DW) - 1)) ? '1 : DW'(q);
    endfunction

    function automatic logic coord_match(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef KMEANS_UPDATE_TOL_EN
        logic [DW-1:0] diff;
        diff = (a > b) ? a - b : b - a;
        return 32'(diff) <= KMEANS_CONV_TOL;
`else
        return a == b;
`endif
    endfunction

    // busy also covers the cycle the done pulse is visible, so no restart overlaps it.
    assign start_acc = (state_q == IDLE) && start && !busy;

    kmeans_seq_div #(.acc_width(acc_width), .input_data_qty_bit_width(input_data_qty_bit_width)) u_div0 (
        .clk(clk), .rst(rst), .load(state_q == READ),
        .dividend(acc0_in), .divisor(acc_counter_in), .quotient(quo0), .valid(vld0)
    );

    kmeans_seq_div #(.acc_width(acc_width), .input_data_qty_bit_width(input_data_qty_bit_width)) u_div1 (
        .clk(clk), .rst(rst), .load(state_q == READ),
        .dividend(acc1_in), .divisor(acc_counter_in), .quotient(quo1), .valid(vld1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_acc) state_d = READ;
            READ:    state_d = DIV;
            DIV:     if (div_cnt_q == CW'(acc_width - 1)) state_d = WRITE;
            WRITE:   state_d = c_q ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_acc_en       = (state_q == READ);
        rd_acc_centroid = c_q;
    end

    // Empty (or wrapped) clusters keep their previous coordinates.
    always_comb begin
        old_d0    = c_q ? old_k1d0 : old_k0d0;
        old_d1    = c_q ? old_k1d1 : old_k0d1;
        upd_d0    = (cnt_q == '0 || !vld0) ? old_d0 : sat(quo0);
        upd_d1    = (cnt_q == '0 || !vld1) ? old_d1 : sat(quo1);
        upd_match = coord_match(upd_d0, old_d0) && coord_match(upd_d1, old_d1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q       <= 1'b0;
            div_cnt_q <= '0;
            cnt_q     <= '0;
            old_k0d0  <= '0;
            old_k0d1  <= '0;
            old_k1d0  <= '0;
            old_k1d1  <= '0;
            match_q   <= '0;
            new_k0d0  <= '0;
            new_k0d1  <= '0;
            new_k1d0  <= '0;
            new_k1d1  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
        end else begin
            done <= 1'b0;
            if (done) busy <= 1'b0;
            case (state_q)
                IDLE: if (start_acc) begin
                    old_k0d0  <= k0d0;
                    old_k0d1  <= k0d1;
                    old_k1d0  <= k1d0;
                    old_k1d1  <= k1d1;
                    c_q       <= 1'b0;
                    busy      <= 1'b1;
                    converged <= 1'b0;
                end
                READ: begin
                    cnt_q     <= acc_counter_in;
                    div_cnt_q <= '0;
                end
                DIV: div_cnt_q <= div_cnt_q + 1'b1;
                WRITE: begin
                    if (!c_q) begin
                        new_k0d0   <= upd_d0;
                        new_k0d1   <= upd_d1;
                        match_q[0] <= upd_match;
                        c_q        <= 1'b1;
                    end else begin
                        new_k1d0   <= upd_d0;
                        new_k1d1   <= upd_d1;
                        match_q[1] <= upd_match;
                    end
                end
                DONE: begin
                    done      <= 1'b1;
                    converged <= &match_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/kmeans_centroid_update_k2n2.md
# kmeans_centroid_update_k2n2

Centroid update stage for the K=2, N=2 k-means datapath. After an accumulation pass, it reads the per-centroid dimension sums and point counts from the accumulator block (`kmeans_acc_block_k2n2`) through its read port. It divides each sum by its count with a sequential divider and registers the four new centroid coordinates. It also reports whether the iteration has converged, and the top-level controller feeds the new coordinates back into the `k0d0..k1d1` registers.

## Interface
- `input_data_width`, default 8: width of one centroid coordinate.
- `input_data_qty_bit_width`, default 8: width of the per-centroid point counter.
- `acc_width`, default 16: width of the accumulated sums and the divider.

Ports:
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin an update. Ignored unless the block is idle.
- `k0d0, k0d1, k1d0, k1d1` in `input_data_width`: current centroids. Captured when `start` is accepted.
- `rd_acc_en` out 1: read-authority request to the accumulator block.
- `rd_acc_centroid` out 1: centroid index presented on the accumulator read port.
- `acc0_in, acc1_in` in `acc_width`: dimension-0 and dimension-1 sums (combinational read data).
- `acc_counter_in` in `input_data_qty_bit_width`: point count for `rd_acc_centroid`.
- `new_k0d0, new_k0d1, new_k1d0, new_k1d1` out `input_data_width`: registered new centroids.
- `busy` out 1: high from accepted `start` through the DONE cycle.
- `done` out 1: one-cycle pulse in DONE.
- `converged` out 1: convergence result, valid from `done` until the next accepted `start`.

## Operation
- FSM states: IDLE, READ, DIV, WRITE, DONE. The index register `c` selects centroid 0 or 1.
- **IDLE:** when `start` is high, capture the old centroids, clear `c` and go to READ.
- **READ (1 cycle):**
  - drive `rd_acc_en`=1 and `rd_acc_centroid`=`c`;
  - latch `acc0_in`, `acc1_in` and `acc_counter_in` at the end of the cycle;
  - go to DIV.
- **DIV:** two divider instances run in parallel, one per dimension, each computing sum / count. The quotient is unsigned and truncated toward zero. DIV lasts exactly `acc_width` cycles, then goes to WRITE.
- **WRITE (1 cycle):** register the new coordinates for centroid `c`.
  - If count == 0 (empty cluster, or a wrapped counter), keep the captured old coordinates.
  - If the quotient is greater than 2^`input_data_width`−1, saturate to all-ones.
  - Evaluate the per-centroid match flag.
  - If `c`==0, set `c`=1 and go to READ; otherwise go to DONE.
- **DONE (1 cycle):** `done`=1 and `converged` = AND of both match flags. Return to IDLE.
- A match means all coordinates of the centroid equal their old values (see Configuration).
- `start` is ignored in every state other than IDLE.
- `rd_acc_en` is 0 in every state other than READ. `rd_acc_centroid` holds `c` at all times.
- Between updates the outputs hold their last values.

## Timing
- Reset values:
  - `new_k*` = 0, `busy` = 0, `done` = 0, `converged` = 0;
  - `rd_acc_en` = 0, `rd_acc_centroid` = 0;
  - FSM = IDLE, `c` = 0.
- Reset is effective immediately (asynchronous). Asserting reset mid-update aborts the update and leaves no partial `new_k*` state beyond the reset values.
- Each centroid takes 1 (READ) + `acc_width` (DIV) + 1 (WRITE) cycles; with defaults that is 18 cycles.
- `start` is sampled at edge T. `done` is high during the cycle following edge T+2·(`acc_width`+2)+1, which is T+37 with defaults.
- `new_k0*` updates at the end of the first WRITE; `new_k1*` updates at the end of the second WRITE.
- `busy` rises at edge T and falls at the edge that ends DONE.
- The accumulator read is combinational. The acc block must not be written (`acc_enable`=0) while `busy` is high; this is the controller's responsibility.

## Configuration
- Macro: `KMEANS_UPDATE_TOL_EN`.
  - **Defined:** a coordinate matches when |new − old| ≤ `KMEANS_CONV_TOL`, compared as unsigned magnitude.
  - **Undefined:** a coordinate matches only when new == old exactly.

## Structure
- Shared package `kmeans_pkg` holds:
  - the FSM state typedef (IDLE/READ/DIV/WRITE/DONE);
  - `KMEANS_K`=2 and `KMEANS_N`=2;
  - `KMEANS_CONV_TOL`=1.
- Sub-module `kmeans_seq_div`: a restoring divider, one quotient bit per cycle.
  - Parameters: dividend width `acc_width`, divisor width `input_data_qty_bit_width`.
  - Ports: `load`, dividend, divisor, quotient, `valid`.
  - Instantiated twice.

## Test plan
- **Reset:** assert `rst` asynchronously mid-DIV → all outputs return to 0 immediately; the next `start` runs a clean 37-cycle update.
- **Basic divide:** centroid 0 with sums (30, 60) and count 3; centroid 1 with sums (100, 200) and count 10 → `new_k0d0`=10, `new_k0d1`=20, `new_k1d0`=10, `new_k1d1`=20; `done` at T+37; `rd_acc_en` high exactly 2 cycles.
- **Truncation and saturation:** sum 7, count 2 → 3; sum 4000, count 2 (quotient 2000) → 255.
- **Empty cluster:** centroid 1 count 0 with old (5, 9) → `new_k1d0`=5, `new_k1d1`=9; no hang.
- **Convergence:**
  - computed values equal old on all 4 coordinates → `converged`=1;
  - one coordinate differs by 1 → `converged`=0 without the macro, 1 with `KMEANS_UPDATE_TOL_EN`.
- **Start while busy:** pulse `start` during DIV → ignored; exactly one `done` pulse and results unchanged.
